// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the int4b multiply-accumulate slice.
// The state encoding is shared so a bench or wrapper can name the phases.
package mult_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_IN_WIDTH  = 12;
    localparam int DEF_NUM_TERMS = 8;
    localparam int DEF_SHIFT     = 4;
    localparam int DEF_RES_WIDTH = 8;

endpackage

// File: rtl/acc_requant.sv
// Requantizer: floor arithmetic right shift, then clip to the signed
// result range, flagging whenever the clip changed the value.
module acc_requant #(
    parameter int ACC_WIDTH = 16,
    parameter int SHIFT     = 4,
    parameter int RES_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [RES_WIDTH-1:0] out_data,
    output logic                        out_sat
);

    localparam int W = ((ACC_WIDTH > RES_WIDTH) ? ACC_WIDTH : RES_WIDTH) + 1;
    localparam logic signed [W-1:0] RMAX =
        W'((64'sd1 <<< (RES_WIDTH - 1)) - 64'sd1);
    localparam logic signed [W-1:0] RMIN = ~RMAX;

    logic signed [ACC_WIDTH-1:0] r;
    logic signed [W-1:0]         rw;

    // Shift with floor semantics, widen, then saturate at either end.
    always_comb begin
        r        = sum >>> SHIFT;
        rw       = W'(r);
        out_sat  = 1'b0;
        out_data = rw[RES_WIDTH-1:0];
        if (rw > RMAX) begin
            out_data = RMAX[RES_WIDTH-1:0];
            out_sat  = 1'b1;
        end else if (rw < RMIN) begin
            out_data = RMIN[RES_WIDTH-1:0];
            out_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/mult_acc_int4b.sv
// Accumulates NUM_TERMS signed products, then presents one requantized
// result with a valid/ready handshake until downstream takes it.
module mult_acc_int4b
    import mult_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int NUM_TERMS = DEF_NUM_TERMS,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(NUM_TERMS) + 1,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int RES_WIDTH = DEF_RES_WIDTH,
    parameter logic signed [ACC_WIDTH-1:0] BIAS = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [RES_WIDTH-1:0] out_data,
    output logic                        out_sat
);

    localparam int CW = $clog2(NUM_TERMS);

    state_t                      state_q;
    state_t                      state_d;
    logic [CW-1:0]               cnt_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] sum_d;
    logic                        accept;
    logic                        last;
    logic signed [RES_WIDTH-1:0] rq_data;
    logic                        rq_sat;

    // Handshakes decode only the registered state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CW'(NUM_TERMS - 1));

    // First term of a result starts from the bias, later terms add on.
    always_comb begin
        sum_d = ((cnt_q == '0) ? BIAS : acc_q) + ACC_WIDTH'(in_data);
    end

    acc_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .RES_WIDTH (RES_WIDTH)
    ) u_requant (
        .sum      (sum_d),
        .out_data (rq_data),
        .out_sat  (rq_sat)
    );

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase: last accept moves to HOLD, a taken result returns to ACC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:  if (accept && last) state_d = HOLD;
            HOLD: if (out_ready)      state_d = ACC;
            default: state_d = ACC;
        endcase
        if (clear) state_d = ACC;
    end

    // Term counter, accumulator and result capture; clear wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clear) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (accept) begin
            acc_q <= sum_d;
            if (last) begin
                cnt_q    <= '0;
                out_data <= rq_data;
                out_sat  <= rq_sat;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_acc_int4b.sv
// Bench for mult_acc_int4b: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic model of the accumulator.
module tb_mult_acc_int4b;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic signed [11:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_sat;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mult_acc_int4b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of a completed sum: floor divide by 16, clip to int8.
    function automatic void requant(input int s, output int d, output bit sat);
        int r;
        r   = (s >= 0) ? (s / 16) : -((-s + 15) / 16);
        sat = 1'b0;
        d   = r;
        if (r > 127) begin
            d   = 127;
            sat = 1'b1;
        end else if (r < -128) begin
            d   = -128;
            sat = 1'b1;
        end
    endfunction

    bit m_hold;
    int m_n;
    int m_sum;
    int m_data;
    bit m_sat;
    int t_d;
    bit t_s;

    // Reference model: count accepted terms, keep a running sum.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_hold <= 1'b0;
            m_n    <= 0;
            m_sum  <= 0;
            m_data <= 0;
            m_sat  <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
        end else if (in_valid) begin
            if (m_n == 7) begin
                requant(m_sum + int'(in_data), t_d, t_s);
                m_data <= t_d;
                m_sat  <= t_s;
                m_hold <= 1'b1;
                m_n    <= 0;
                m_sum  <= 0;
            end else begin
                m_n   <= m_n + 1;
                m_sum <= m_sum + int'(in_data);
            end
        end
    end

    // Compare all outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            chk("out_data", out_data, m_data);
            chk("out_sat", out_sat, m_sat);
        end
    end

    task automatic fill(input int v);
        in_valid = 1'b1;
        in_data  = 12'(v);
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_const(input int v, input int ed, input int es);
        in_valid  = 1'b1;
        in_data   = 12'(v);
        out_ready = 1'b0;
        repeat (7) @(negedge clk);
        chk("early_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lit_valid", out_valid, 1);
        chk("lit_data", out_data, ed);
        chk("lit_sat", out_sat, es);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after", in_ready, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("init_valid", out_valid, 0);
        chk("init_ready", in_ready, 1);
        chk("init_data", out_data, 0);
        chk("init_sat", out_sat, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_const(100, 50, 0);
        run_const(-2048, -128, 1);
        run_const(2047, 127, 1);
        run_const(-1, -1, 0);

        fill(48);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 12'(500);
            @(negedge clk);
            chk("hold_data", out_data, 24);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_const(7, 3, 0);

        in_valid = 1'b1;
        in_data  = 12'(200);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        run_const(16, 8, 0);

        in_valid = 1'b1;
        in_data  = 12'(300);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        pulse_reset();
        run_const(32, 16, 0);
        fill(100);
        pulse_reset();
        run_const(32, 16, 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 49) == 0);
            if (i[8])
                in_data = 12'($urandom);
            else
                in_data = 12'(int'($urandom_range(0, 255)) - 128);
            @(negedge clk);
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_acc_int4b.md
MULT_ACC_INT4B -- requirements
Module: mult_acc_int4b

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 12: signed width of incoming product (4b operand x 8b coefficient).
REQ-002 SHALL have parameter NUM_TERMS, default 8: products summed per result (power of two, >=2).
REQ-003 SHALL have parameter ACC_WIDTH, default IN_WIDTH+$clog2(NUM_TERMS)+1: signed accumulator width.
REQ-004 SHALL have parameter SHIFT, default 4: arithmetic right shift applied before requantization.
REQ-005 SHALL have parameter RES_WIDTH, default 8: signed result width.
REQ-006 SHALL have parameter BIAS, default 0: signed ACC_WIDTH preload, |BIAS| < 2^(ACC_WIDTH-2).
REQ-007 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port clear  input  1  synchronous abort of current accumulation.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-012 SHALL have port in_data  input  IN_WIDTH  signed product from upstream multiplier.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_data  output  RES_WIDTH  signed requantized sum.
REQ-016 SHALL have port out_sat  output  1  out_data was clipped.

Function
REQ-017 SHALL implement two states: ACC (collecting terms) and HOLD (result presented).
REQ-018 SHALL drive in_ready=1 exactly in ACC and out_valid=1 exactly in HOLD, both registered-state decodes, no combinational path from out_ready to in_ready.
REQ-019 SHALL accept a term when in_valid&&in_ready; term counter cnt (0..NUM_TERMS-1) increments per accept.
REQ-020 SHALL load acc <= BIAS + sext(in_data) on the accept with cnt==0, and acc <= acc + sext(in_data) on later accepts; no internal wrap possible within parameter limits.
REQ-021 SHALL, on the accept with cnt==NUM_TERMS-1, register out_data/out_sat from the final sum and enter HOLD next cycle (out_valid one cycle after last accept).
REQ-022 SHALL compute r = final_sum >>> SHIFT (floor); out_data = r clipped to [-2^(RES_WIDTH-1), 2^(RES_WIDTH-1)-1]; out_sat=1 iff clipped.
REQ-023 SHALL hold out_data and out_sat stable while out_valid&&!out_ready.
REQ-024 SHALL on out_valid&&out_ready return to ACC with cnt=0 next cycle; minimum period NUM_TERMS+1 cycles per result.
REQ-025 SHALL ignore in_valid in HOLD; in_data is not consumed.
REQ-026 SHALL give clear priority over all events: next cycle state=ACC, cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0; a term presented with clear is discarded.

Reset
REQ-027 SHALL on rst_n low asynchronously set state=ACC, cnt=0, acc=0, out_data=0, out_sat=0, out_valid=0; in_ready=1 after reset.
REQ-028 SHALL, on reset mid-accumulation or in HOLD, discard partial sums and pending results.

Structure
REQ-029 SHALL place the state typedef (ACC, HOLD) and default widths in package mult_acc_pkg.
REQ-030 SHALL implement shift+clip in one combinational sub-module acc_requant (ports: sum, out_data, out_sat).

Verification
REQ-031 SHALL test 8 terms of +100, SHIFT=4, BIAS=0 -> out_data=50, out_sat=0, out_valid one cycle after 8th accept.
REQ-032 SHALL test 8 terms of -2048 -> sum -16384, r=-1024 -> out_data=-128, out_sat=1; 8 terms of +2047 -> out_data=127, out_sat=1.
REQ-033 SHALL test 8 terms of -1 -> sum -8, r=-1 (floor) -> out_data=-1, out_sat=0.
REQ-034 SHALL test out_ready low 5 cycles in HOLD -> out_data constant, in_ready=0, in_valid pulses not counted; next result correct.
REQ-035 SHALL test clear after 3 terms, then 8 terms of +16 -> out_data=8 (aborted terms excluded).
REQ-036 SHALL test rst_n pulsed low mid-accumulation and in HOLD -> all outputs 0 immediately, in_ready=1 after release, following 8 terms of +32 -> out_data=16.
